// File: rtl/pc_call_stack.sv
// Program counter with an integrated return-address stack.
// Controls are prioritised: ret > call > load > rel > inc > hold. Stall freezes everything but reset.
module pc_call_stack #(
    parameter int unsigned        WIDTH       = 16,
    parameter int unsigned        DEPTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    localparam int unsigned       CW          = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             rel,
    input  logic             call,
    input  logic             ret,
    input  logic             stall,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic [WIDTH-1:0] pc_plus_one;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             push_en;

    assign pc_plus_one = out_q + WIDTH'(1);
    assign top_idx     = AW'(count_q - CW'(1));
    // Only used when count_q < DEPTH, so it always fits the index width.
    assign wr_idx      = AW'(count_q);

    always_comb begin
        out_d       = out_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push_en     = 1'b0;
        if (!stall) begin
            if (ret) begin
                if (count_q != '0) begin
                    out_d   = stack_q[top_idx];
                    count_d = count_q - CW'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end else if (call) begin
                // The jump is taken even when the stack is full; only the push is dropped.
                out_d = in;
                if (count_q != DEPTH_C) begin
                    push_en = 1'b1;
                    count_d = count_q + CW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (load) begin
                out_d = in;
            end else if (rel) begin
                out_d = out_q + in;
            end else if (inc) begin
                out_d = pc_plus_one;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q       <= RESET_VALUE;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push_en) begin
            stack_q[wr_idx] <= pc_plus_one;
        end
    end

    assign out       = out_q;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
